acorn_finalize_par: RTL
=======================

// Module: acorn_finalize_par
// PURPOSE
//  ACORN-128 finalization engine, parametrised successor of the bit-serial finalizer.
//  Takes the 293-bit state left after plaintext/ciphertext processing and runs the 768 finalization steps
//  (m=0, ca=1, cb=1), STEPS_PER_CYCLE steps per clock.
//  Collects the last TAG_BITS keystream bits as the tag.
//  Sits between the encrypt/decrypt datapath and the tag output / compare stage of the AEAD core.
// PARAMETERS
//  STEPS_PER_CYCLE  1    steps unrolled per clock; one of 1,2,4,8,16,32 (divides 768 and TAG_BITS)
//  TAG_BITS         128  tag length; multiple of STEPS_PER_CYCLE, 32..128
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         request finalization; sampled only in IDLE
//  abort      in   1         synchronous cancel; returns to IDLE, clears tag_valid
//  state_in   in   293       ACORN state S[292:0], sampled on accepted start
//  busy       out  1         high while steps are running
//  done       out  1         one-cycle pulse when the last step group completes
//  tag_valid  out  1         high from done until next accepted start/abort/reset
//  tag        out  TAG_BITS  authentication tag
//  state_out  out  293       final state after 768 steps; valid while tag_valid
// BEHAVIOUR
//  - Reset values:
//    - FSM=IDLE; busy, done, tag_valid = 0.
//    - tag = 0; state_out = 0; step counter = 0.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE & start: load state_in into the state register; step_cnt=0; go RUN.
//    - RUN: each clock applies STEPS_PER_CYCLE chained StateUpdate128 steps (ACORN-128 v3, m=0, ca=1, cb=1).
//      - Keystream bit of step i is computed from the state before step i.
//      - step_cnt += STEPS_PER_CYCLE.
//    - RUN, group containing step 767 applied: go DONE.
//      - done=1 for that one cycle (registered, coincident with the final state).
//      - Then go IDLE with tag_valid=1.
//  - Latency: start accepted at edge N -> busy=1 from N..N+768/SPC-1 -> done at edge N+768/SPC.
//    - SPC=1: 768 cycles; SPC=8: 96; SPC=32: 24.
//  - Tag capture: keystream bits of steps 768-TAG_BITS .. 767 only.
//    - Step 768-TAG_BITS -> tag[0]; step 767 -> tag[TAG_BITS-1] (LSB = earliest).
//    - Within a group, lane k (step_cnt+k) maps to tag bit (step_cnt+k-(768-TAG_BITS)).
//    - tag bits hold 0 until written; no OR/accumulate, direct bit placement.
//  - start while busy or in DONE: ignored; no restart, no error.
//  - start and abort in the same cycle: abort wins; stays IDLE.
//  - abort in RUN: IDLE next cycle, busy=0, no done.
//    - tag/state_out keep partial contents; tag_valid=0.
//  - Accepted start clears tag_valid and zeroes tag on the same edge.
//  - rst mid-run: immediate return to reset values; nothing retained.
//  - step_cnt: 10 bits, never wraps; compares against 768-SPC for the last group.
// CONFIGURATION
//  ACORN_FIN_TAG_CMP_EN defined:
//    - Adds input expected_tag[TAG_BITS-1:0], sampled with start.
//    - Adds output tag_ok.
//      - tag_ok=1 with done iff tag==expected_tag (constant-time full compare).
//      - Holds with tag_valid; 0 at reset/start/abort.
//  ACORN_FIN_TAG_CMP_EN undefined:
//    - No expected_tag/tag_ok ports.
//    - Comparison is done by the caller.
// TESTING
//  1 Reset: assert rst mid-sim -> busy=done=tag_valid=0, tag=0, state_out=0 on the same cycle.
//  2 Golden vector: key=0, IV=0, empty AD/PT; state_in from init model; SPC=1, TAG_BITS=128
//    -> tag equals C reference tag; done exactly 768 cycles after start.
//  3 Unroll equivalence: same state_in with SPC=1,8,32 -> identical tag and state_out;
//    done after 768/96/24 cycles.
//  4 Truncation: TAG_BITS=64, SPC=8, vector of test 2 -> tag == tag128[127:64]; done after 96 cycles.
//  5 Handshake: start pulsed at +5 during RUN, then abort at +100
//    -> no restart; busy falls the next cycle, no done, tag_valid=0; fresh start then completes normally.
//  6 CMP_EN: expected_tag = golden -> tag_ok=1 with done;
//    flip expected_tag[0] -> tag_ok=0, done timing unchanged.

Source files
------------

// File: rtl/acorn_finalize_par.sv
// ACORN-128 finalization engine: 768 StateUpdate128 steps (m=0, ca=1, cb=1), STEPS_PER_CYCLE per clock,
// last TAG_BITS keystream bits kept as the tag. Optional tag compare under `ACORN_FIN_TAG_CMP_EN.
module acorn_finalize_par #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int TAG_BITS        = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [292:0]        state_in,
`ifdef ACORN_FIN_TAG_CMP_EN
  input  logic [TAG_BITS-1:0] expected_tag,
  output logic                tag_ok,
`endif
  output logic                busy,
  output logic                done,
  output logic                tag_valid,
  output logic [TAG_BITS-1:0] tag,
  output logic [292:0]        state_out
);

  localparam int NUM_STEPS  = 768;
  localparam int TAG_START  = NUM_STEPS - TAG_BITS;
  localparam int TAG_GROUPS = TAG_BITS / STEPS_PER_CYCLE;
  localparam logic [9:0] LAST_CNT = 10'(NUM_STEPS - STEPS_PER_CYCLE);
  localparam logic [9:0] CNT_INC  = 10'(STEPS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [292:0]        state_q, state_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic                tag_valid_q, tag_valid_d;
  logic                done_q, done_d;
  logic                last_grp;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // One StateUpdate128 step; returns {keystream bit, next state}.
  function automatic logic [293:0] acorn_step(input logic [292:0] s_in);
    logic [292:0] s;
    logic         ks;
    logic         fb;
    s      = s_in;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    fb = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ s[196] ^ ks;
    return {ks, fb, s[292:1]};
  endfunction

  logic [292:0]               chain [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] ks_vec;

  assign chain[0] = state_q;

  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      assign {ks_vec[gi], chain[gi+1]} = acorn_step(chain[gi]);
    end
  endgenerate

`ifdef ACORN_FIN_TAG_CMP_EN
  logic [TAG_BITS-1:0] expected_q, expected_d;
  logic                tag_ok_q, tag_ok_d;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    done_d      = 1'b0;
    last_grp    = (cnt_q == LAST_CNT);
`ifdef ACORN_FIN_TAG_CMP_EN
    expected_d  = expected_q;
    tag_ok_d    = tag_ok_q;
`endif
    // Abort overrides everything and freezes the partial state/tag.
    if (abort) begin
      fsm_d       = IDLE;
      tag_valid_d = 1'b0;
`ifdef ACORN_FIN_TAG_CMP_EN
      tag_ok_d    = 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_d     = state_in;
            cnt_d       = '0;
            tag_d       = '0;
            tag_valid_d = 1'b0;
            fsm_d       = RUN;
`ifdef ACORN_FIN_TAG_CMP_EN
            expected_d  = expected_tag;
            tag_ok_d    = 1'b0;
`endif
          end
        end
        RUN: begin
          state_d = chain[STEPS_PER_CYCLE];
          cnt_d   = cnt_q + CNT_INC;
          // Groups are aligned to the tag window, so each group owns one slice.
          for (int g = 0; g < TAG_GROUPS; g++) begin
            if (cnt_q == 10'(TAG_START + g * STEPS_PER_CYCLE))
              tag_d[g*STEPS_PER_CYCLE +: STEPS_PER_CYCLE] = ks_vec;
          end
          if (last_grp) begin
            fsm_d       = DONE;
            done_d      = 1'b1;
            tag_valid_d = 1'b1;
`ifdef ACORN_FIN_TAG_CMP_EN
            tag_ok_d    = ~|(tag_d ^ expected_q);
`endif
          end
        end
        DONE:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef ACORN_FIN_TAG_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= '0;
      tag_ok_q   <= 1'b0;
    end else begin
      expected_q <= expected_d;
      tag_ok_q   <= tag_ok_d;
    end
  end

  assign tag_ok = tag_ok_q;
`endif

  assign busy      = (fsm_q == RUN);
  assign done      = done_q;
  assign tag_valid = tag_valid_q;
  assign tag       = tag_q;
  assign state_out = state_q;

endmodule
